// File: rtl/sap_pkg.sv
// Shared constants for the SAP datapath: control-word bit indices, opcodes and default widths.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;
  localparam int CTRL_W     = 15;

  localparam int SIG_CP   = 14;
  localparam int SIG_EP   = 13;
  localparam int SIG_LP   = 12;
  localparam int SIG_NLMA = 11;
  localparam int SIG_NLMD = 10;
  localparam int SIG_NCE  = 9;
  localparam int SIG_NLR  = 8;
  localparam int SIG_NLI  = 7;
  localparam int SIG_NEI  = 6;
  localparam int SIG_NLA  = 5;
  localparam int SIG_EA   = 4;
  localparam int SIG_SU   = 3;
  localparam int SIG_EU   = 2;
  localparam int SIG_NLB  = 1;
  localparam int SIG_NLO  = 0;

  // No-operation control word: active-high bits at 0, active-low bits at 1
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_OUT = 4'h6,
    OP_JMP = 4'h7
  } opcode_t;

  function automatic int unsigned count_ones(input logic [4:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// Program/data RAM: synchronous write, asynchronous read; the program-load port wins over the CPU write.
module sap_ram16x8
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents deliberately survive reset so a loaded program is kept.
  always_ff @(posedge clk) begin
    if (prog_we)  mem[prog_addr] <= prog_data;
    else if (we)  mem[addr]      <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sap_datapath.sv
// SAP bus datapath: PC, MAR, MDR, RAM, IR, A, B, adder/subtractor and OUT on a shared OR bus.
// Optional carry/zero flags are built when SAP_FLAGS_EN is defined.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              bus_conflict
`ifdef SAP_FLAGS_EN
  ,
  output logic              flag_c,
  output logic              flag_z
`endif
);

  logic c_p, e_p, l_p, ld_ma, ld_md, ce, ld_r, ld_i, e_i, ld_a, e_a, s_u, e_u, ld_b, ld_o;

  assign c_p   =  ctrl[SIG_CP];
  assign e_p   =  ctrl[SIG_EP];
  assign l_p   =  ctrl[SIG_LP];
  assign ld_ma = ~ctrl[SIG_NLMA];
  assign ld_md = ~ctrl[SIG_NLMD];
  assign ce    = ~ctrl[SIG_NCE];
  assign ld_r  = ~ctrl[SIG_NLR];
  assign ld_i  = ~ctrl[SIG_NLI];
  assign e_i   = ~ctrl[SIG_NEI];
  assign ld_a  = ~ctrl[SIG_NLA];
  assign e_a   =  ctrl[SIG_EA];
  assign s_u   =  ctrl[SIG_SU];
  assign e_u   =  ctrl[SIG_EU];
  assign ld_b  = ~ctrl[SIG_NLB];
  assign ld_o  = ~ctrl[SIG_NLO];

  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] mdr, ir, a, b;
  logic [DATA_W-1:0] ram_rd, alu_res, bus;

  sap_ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .we        (ld_r),
    .addr      (mar),
    .wdata     (mdr),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rdata     (ram_rd)
  );

`ifdef SAP_FLAGS_EN
  // Subtract as A + ~B + 1 so the top bit is the no-borrow indication.
  logic [DATA_W:0] alu_full;
  assign alu_full = s_u ? ({1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1))
                        : ({1'b0, a} + {1'b0, b});
  assign alu_res  = alu_full[DATA_W-1:0];
`else
  assign alu_res = s_u ? (a - b) : (a + b);
`endif

  logic [4:0] drv_en;
  assign drv_en = {e_p, ce, e_i, e_a, e_u};

  always_comb begin
    bus = '0;
    if (e_p) bus = bus | DATA_W'(pc);
    if (ce)  bus = bus | ram_rd;
    if (e_i) bus = bus | DATA_W'(ir[3:0]);
    if (e_a) bus = bus | a;
    if (e_u) bus = bus | alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      mar          <= '0;
      mdr          <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      out_val      <= '0;
      bus_conflict <= 1'b0;
    end else begin
      if (l_p)      pc <= bus[ADDR_W-1:0];
      else if (c_p) pc <= pc + 1'b1;
      if (ld_ma) mar     <= bus[ADDR_W-1:0];
      if (ld_md) mdr     <= bus;
      if (ld_i)  ir      <= bus;
      if (ld_a)  a       <= bus;
      if (ld_b)  b       <= bus;
      if (ld_o)  out_val <= a;
      if (count_ones(drv_en) >= 2) bus_conflict <= 1'b1;
    end
  end

`ifdef SAP_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (ld_a && e_u) begin
      flag_c <= alu_full[DATA_W];
      flag_z <= (alu_res == '0);
    end
  end
`endif

  assign opcode  = ir[DATA_W-1 -: 4];
  assign bus_dbg = bus;

endmodule
